// File: rtl/csr_check_pkg.sv
// Shared types for the CSR structure checker: sparsity mode, error codes, FSM states.
package csr_check_pkg;

    localparam int CSR_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_DIAG  = 2'd0,
        MODE_BAND  = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_UPPER = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_PTR0  = 3'd1,
        ERR_MONO  = 3'd2,
        ERR_NNZ   = 3'd3,
        ERR_RANGE = 3'd4,
        ERR_ORDER = 3'd5,
        ERR_SHAPE = 3'd6
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PTR0 = 3'd1,
        ST_PTR  = 3'd2,
        ST_COL  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/csr_col_rule.sv
// Per-entry column check: range, strict ordering within a row, then sparsity pattern.
module csr_col_rule
    import csr_check_pkg::*;
#(
    parameter int WIDTH = CSR_WIDTH
) (
    input  logic [WIDTH-1:0] col,
    input  logic [WIDTH-1:0] row,
    input  logic [WIDTH-1:0] prev_col,
    input  logic             first,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] band_lo,
    input  logic [WIDTH-1:0] band_hi,
    input  logic [WIDTH-1:0] num_rows,
    output err_e             err
);

    // Band limits are compared with one extra bit so row+band_hi and
    // col+band_lo never wrap (row-band_lo <= col rewritten as row <= col+band_lo).
    logic [WIDTH:0] col_x;
    logic [WIDTH:0] row_x;
    logic [WIDTH:0] lo_sum;
    logic [WIDTH:0] hi_sum;
    logic           shape_bad;

    assign col_x  = {1'b0, col};
    assign row_x  = {1'b0, row};
    assign lo_sum = col_x + {1'b0, band_lo};
    assign hi_sum = row_x + {1'b0, band_hi};

    // Pattern test for the selected mode, then prioritised error selection.
    always_comb begin
        shape_bad = 1'b0;
        case (mode)
            MODE_DIAG:  shape_bad = (col != row);
            MODE_BAND:  shape_bad = (lo_sum < row_x) || (col_x > hi_sum);
            MODE_LOWER: shape_bad = (col > row);
            MODE_UPPER: shape_bad = (col < row);
            default:    shape_bad = 1'b0;
        endcase

        err = ERR_NONE;
        if (col >= num_rows)
            err = ERR_RANGE;
        else if (!first && (col <= prev_col))
            err = ERR_ORDER;
        else if (shape_bad)
            err = ERR_SHAPE;
    end

endmodule

// File: rtl/csr_pattern_checker.sv
// Single-pass CSR structure verifier: walks row pointers and column indices,
// latches the first error and reports it with a one-cycle done pulse.
module csr_pattern_checker
    import csr_check_pkg::*;
#(
    parameter int WIDTH = CSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_rows,
    input  logic [WIDTH-1:0] nnz,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] band_lo,
    input  logic [WIDTH-1:0] band_hi,
    input  logic [WIDTH-1:0] ptr_data,
    input  logic             ptr_valid,
    output logic             ptr_ready,
    input  logic [WIDTH-1:0] col_data,
    input  logic             col_valid,
    output logic             col_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       err_code,
    output logic [WIDTH-1:0] err_row
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] rows_q, nnz_q, blo_q, bhi_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] row_q, cnt_q, prev_q, lastcol_q;
    logic             first_q;
    err_e             err_q;
    logic [WIDTH-1:0] erow_q;
    logic             pass_q;
    logic [2:0]       err_code_q;
    logic [WIDTH-1:0] err_row_q;

    logic             ptr_fire, col_fire, last_row;
    logic [WIDTH-1:0] row_inc, ptr_cnt, final_off;
    err_e             rule_err, new_err, err_d;
    logic [WIDTH-1:0] erow_d;
    logic             abort, end_chk;

    // Readies decode only the registered state, so valid never feeds ready.
    assign ptr_ready = (state_q == ST_PTR0) || (state_q == ST_PTR);
    assign col_ready = (state_q == ST_COL);
    assign busy      = ptr_ready || col_ready;
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_code  = err_code_q;
    assign err_row   = err_row_q;

    assign ptr_fire = ptr_valid && ptr_ready;
    assign col_fire = col_valid && col_ready;
    assign row_inc  = row_q + ONE;
    assign last_row = (row_inc == rows_q);
    assign ptr_cnt  = ptr_data - prev_q;

    csr_col_rule #(.WIDTH(WIDTH)) u_rule (
        .col      (col_data),
        .row      (row_q),
        .prev_col (lastcol_q),
        .first    (first_q),
        .mode     (mode_q),
        .band_lo  (blo_q),
        .band_hi  (bhi_q),
        .num_rows (rows_q),
        .err      (rule_err)
    );

    // Classify the current transfer: error raised, abort, or end of matrix.
    always_comb begin
        new_err   = ERR_NONE;
        abort     = 1'b0;
        end_chk   = 1'b0;
        final_off = ptr_data;
        case (state_q)
            ST_PTR0: if (ptr_fire) begin
                if (ptr_data != '0) begin
                    new_err = ERR_PTR0;
                    abort   = 1'b1;
                end else if (rows_q == '0) begin
                    end_chk = 1'b1;
                end
            end
            ST_PTR: if (ptr_fire) begin
                if (ptr_data < prev_q) begin
                    new_err = ERR_MONO;
                    abort   = 1'b1;
                end else if (ptr_data > nnz_q) begin
                    new_err = ERR_NNZ;
                    abort   = 1'b1;
                end else begin
                    if ((mode_q == MODE_DIAG) && (ptr_cnt != ONE))
                        new_err = ERR_SHAPE;
                    if ((ptr_cnt == '0) && last_row)
                        end_chk = 1'b1;
                end
            end
            ST_COL: if (col_fire) begin
                new_err   = rule_err;
                final_off = prev_q;
                if ((cnt_q == ONE) && last_row)
                    end_chk = 1'b1;
            end
            default: ;
        endcase
        // Final offset must equal nnz once every row has been walked.
        if (end_chk && (new_err == ERR_NONE) && (final_off != nnz_q))
            new_err = ERR_NNZ;
        // Only the first error of a check is kept.
        err_d  = (err_q == ERR_NONE) ? new_err : err_q;
        erow_d = (err_q == ERR_NONE) ? row_q   : erow_q;
    end

    // Checker FSM with its counters and first-error latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            nnz_q      <= '0;
            blo_q      <= '0;
            bhi_q      <= '0;
            mode_q     <= MODE_DIAG;
            row_q      <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            lastcol_q  <= '0;
            first_q    <= 1'b1;
            err_q      <= ERR_NONE;
            erow_q     <= '0;
            pass_q     <= 1'b0;
            err_code_q <= '0;
            err_row_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    rows_q     <= num_rows;
                    nnz_q      <= nnz;
                    blo_q      <= band_lo;
                    bhi_q      <= band_hi;
                    mode_q     <= mode_e'(mode);
                    row_q      <= '0;
                    prev_q     <= '0;
                    err_q      <= ERR_NONE;
                    erow_q     <= '0;
                    pass_q     <= 1'b0;
                    err_code_q <= '0;
                    err_row_q  <= '0;
                    state_q    <= ST_PTR0;
                end
                ST_PTR0: if (ptr_fire) begin
                    err_q   <= err_d;
                    erow_q  <= erow_d;
                    prev_q  <= '0;
                    state_q <= ST_PTR;
                end
                ST_PTR: if (ptr_fire) begin
                    err_q     <= err_d;
                    erow_q    <= erow_d;
                    prev_q    <= ptr_data;
                    first_q   <= 1'b1;
                    lastcol_q <= '0;
                    if (ptr_cnt == '0) begin
                        row_q <= row_inc;
                    end else begin
                        cnt_q   <= ptr_cnt;
                        state_q <= ST_COL;
                    end
                end
                ST_COL: if (col_fire) begin
                    err_q     <= err_d;
                    erow_q    <= erow_d;
                    lastcol_q <= col_data;
                    first_q   <= 1'b0;
                    cnt_q     <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        row_q   <= row_inc;
                        state_q <= ST_PTR;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            // Aborts and normal completion both publish the result on entering DONE.
            if (abort || end_chk) begin
                state_q    <= ST_DONE;
                pass_q     <= (err_d == ERR_NONE);
                err_code_q <= err_d;
                err_row_q  <= (err_d == ERR_NONE) ? '0 : erow_d;
            end
        end
    end

endmodule

// File: tb/tb_csr_pattern_checker.sv
// Table-driven bench with a result scoreboard for csr_pattern_checker.
module tb_csr_pattern_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_rows = '0, nnz = '0, band_lo = '0, band_hi = '0;
    logic [1:0]  mode = '0;
    logic [15:0] ptr_data = '0, col_data = '0;
    logic        ptr_valid = 1'b0, col_valid = 1'b0;
    logic        ptr_ready, col_ready, busy, done, pass;
    logic [2:0]  err_code;
    logic [15:0] err_row;

    csr_pattern_checker #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .nnz       (nnz),
        .mode      (mode),
        .band_lo   (band_lo),
        .band_hi   (band_hi),
        .ptr_data  (ptr_data),
        .ptr_valid (ptr_valid),
        .ptr_ready (ptr_ready),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_code  (err_code),
        .err_row   (err_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode; int nrows; int nnz; int blo; int bhi; bit gaps;
        int pb; int np; int cb; int nc;
        int exp_err; int exp_row; int exp_np; int exp_nc;
    } vec_t;

    typedef struct { int err; int row; int np; int nc; } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   ppool[$];
    int   cpool[$];
    int   pq[$];
    int   cq[$];
    int   n_vec = 0;
    int   n_checks = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Append a vector; streams come from pq/cq, exp_np/exp_nc < 0 means "all items".
    task automatic add_vec(input int md, input int nr, input int nz, input int lo, input int hi,
                           input bit gp, input int e_err, input int e_row,
                           input int e_np, input int e_nc);
        vec_t t;
        t.mode = md; t.nrows = nr; t.nnz = nz; t.blo = lo; t.bhi = hi; t.gaps = gp;
        t.pb = ppool.size(); t.np = pq.size();
        t.cb = cpool.size(); t.nc = cq.size();
        foreach (pq[i]) ppool.push_back(pq[i]);
        foreach (cq[i]) cpool.push_back(cq[i]);
        t.exp_err = e_err; t.exp_row = e_row;
        t.exp_np = (e_np < 0) ? pq.size() : e_np;
        t.exp_nc = (e_nc < 0) ? cq.size() : e_nc;
        vecs.push_back(t);
    endtask

    // Drive one check through the DUT and compare against the scoreboard entry.
    task automatic run_vec(input int v);
        vec_t t;
        exp_t e;
        exp_t got_e;
        int   pi, ci;
        bit   got, pf, cf;
        string tag;
        t = vecs[v];
        tag = $sformatf("v%0d", v);
        e.err = t.exp_err; e.row = t.exp_row; e.np = t.exp_np; e.nc = t.exp_nc;
        sb.push_back(e);
        n_vec++;

        @(negedge clk);
        start = 1'b1;
        num_rows = 16'(t.nrows); nnz = 16'(t.nnz); mode = 2'(t.mode);
        band_lo = 16'(t.blo); band_hi = 16'(t.bhi);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " err_cleared"}, err_code, 0);
        chk({tag, " pass_cleared"}, pass, 0);

        pi = 0; ci = 0; got = 0;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                ptr_valid = (pi < t.np) && !(t.gaps && $urandom_range(0, 2) == 0);
                ptr_data  = (pi < t.np) ? 16'(ppool[t.pb + pi]) : 16'h0;
                col_valid = (ci < t.nc) && !(t.gaps && $urandom_range(0, 2) == 0);
                col_data  = (ci < t.nc) ? 16'(cpool[t.cb + ci]) : 16'h0;
                if (t.gaps) begin
                    // A stray start with junk config while busy must be ignored.
                    start    = 1'(($urandom_range(0, 1)));
                    num_rows = 16'($urandom);
                    nnz      = 16'($urandom);
                    mode     = 2'($urandom);
                end
                pf = ptr_valid && ptr_ready;
                cf = col_valid && col_ready;
                @(posedge clk);
                if (pf) pi++;
                if (cf) ci++;
                @(negedge clk);
            end
        end
        start = 1'b0; ptr_valid = 1'b0; col_valid = 1'b0;

        got_e = sb.pop_front();
        chk({tag, " done_seen"}, int'(got), 1);
        if (got) begin
            chk({tag, " pass"}, pass, (got_e.err == 0) ? 1 : 0);
            chk({tag, " err_code"}, err_code, got_e.err);
            chk({tag, " err_row"}, err_row, got_e.row);
            chk({tag, " ptr_consumed"}, pi, got_e.np);
            chk({tag, " col_consumed"}, ci, got_e.nc);
            chk({tag, " busy_at_done"}, busy, 0);
            chk({tag, " readies_at_done"}, {ptr_ready, col_ready}, 0);
            @(negedge clk);
            chk({tag, " done_one_cycle"}, done, 0);
            chk({tag, " err_hold"}, err_code, got_e.err);
        end
        $display("vector %0d: mode=%0d rows=%0d err_code=%0d err_row=%0d ptr=%0d col=%0d",
                 v, t.mode, t.nrows, err_code, err_row, pi, ci);
    endtask

    initial begin
        // 0 identity DIAG
        pq = '{0, 1, 2, 3, 4}; cq = '{0, 1, 2, 3};
        add_vec(0, 4, 4, 0, 0, 0, 0, 0, -1, -1);
        // 1 tridiagonal BAND 1/1
        pq = '{0, 2, 5, 8, 10}; cq = '{0, 1, 0, 1, 2, 1, 2, 3, 2, 3};
        add_vec(1, 4, 10, 1, 1, 0, 0, 0, -1, -1);
        // 2 tridiagonal checked as DIAG: SHAPE row 0, everything drained
        add_vec(0, 4, 10, 0, 0, 0, 6, 0, -1, -1);
        // 3 pointer decrease: MONO row 1, abort
        pq = '{0, 2, 1, 3}; cq = '{0, 1, 2};
        add_vec(3, 3, 4, 0, 0, 0, 2, 1, 3, 2);
        // 4 column order: ORDER row 0
        pq = '{0, 2, 2, 2, 2}; cq = '{2, 1};
        add_vec(3, 4, 2, 0, 0, 0, 5, 0, -1, -1);
        // 5 column range: RANGE row 2
        pq = '{0, 1, 2, 3}; cq = '{0, 1, 3};
        add_vec(2, 3, 3, 0, 0, 0, 4, 2, -1, -1);
        // 6 final offset below nnz: NNZ at end, last row
        pq = '{0, 1, 2, 3, 4}; cq = '{0, 1, 2, 3};
        add_vec(0, 4, 5, 0, 0, 0, 3, 3, -1, -1);
        // 7 offsets[0] nonzero: PTR0 immediate abort
        pq = '{1, 2, 3}; cq = '{0, 1};
        add_vec(2, 2, 3, 0, 0, 0, 1, 0, 1, 0);
        // 8 offset beyond nnz: NNZ abort
        pq = '{0, 3, 3}; cq = '{0};
        add_vec(2, 2, 2, 0, 0, 0, 3, 0, 2, 0);
        // 9 empty matrix, clean
        pq = '{0}; cq = '{};
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
        // 10 empty matrix, nnz mismatch
        add_vec(0, 0, 1, 0, 0, 0, 3, 0, -1, -1);
        // 11 BAND lo=0 hi=2: row 2 col 0 below band
        pq = '{0, 1, 1, 2}; cq = '{2, 0};
        add_vec(1, 3, 2, 0, 2, 0, 6, 2, -1, -1);
        // 12 BAND with maximal lo limit: no wrap
        pq = '{0, 1, 2}; cq = '{0, 0};
        add_vec(1, 2, 2, 16'hFFFF, 0, 0, 0, 0, -1, -1);
        // 13 BAND with maximal hi limit: no wrap
        pq = '{0, 1, 2}; cq = '{1, 1};
        add_vec(1, 2, 2, 0, 16'hFFFF, 0, 0, 0, -1, -1);
        // 14 DIAG with an empty row: SHAPE row 1
        pq = '{0, 1, 1, 2}; cq = '{0, 2};
        add_vec(0, 3, 2, 0, 0, 0, 6, 1, -1, -1);
        // 15..17 backpressure variants
        pq = '{0, 2, 5, 8, 10}; cq = '{0, 1, 0, 1, 2, 1, 2, 3, 2, 3};
        add_vec(1, 4, 10, 1, 1, 1, 0, 0, -1, -1);
        pq = '{0, 2, 1, 3}; cq = '{0, 1, 2};
        add_vec(3, 3, 4, 0, 0, 1, 2, 1, 3, 2);
        pq = '{0, 1, 2, 3}; cq = '{0, 1, 3};
        add_vec(2, 3, 3, 0, 0, 1, 4, 2, -1, -1);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err_code", err_code, 0);
        chk("rst err_row", err_row, 0);
        chk("rst readies", {ptr_ready, col_ready}, 0);
        rst = 1'b1;

        for (int v = 0; v < vecs.size(); v++) run_vec(v);

        // Reset in the middle of a column phase, then a clean check.
        begin
            bit in_col;
            @(negedge clk);
            start = 1'b1; num_rows = 16'd4; nnz = 16'd4; mode = 2'd0;
            @(negedge clk);
            start = 1'b0;
            ptr_valid = 1'b1; ptr_data = 16'd0;
            @(negedge clk);
            ptr_data = 16'd1;
            in_col = 1'b0;
            for (int c = 0; c < 10 && !in_col; c++) begin
                @(negedge clk);
                ptr_valid = 1'b0;
                in_col = col_ready;
            end
            chk("midcol reached_col", int'(in_col), 1);
            rst = 1'b0;
            #1;
            chk("midcol busy", busy, 0);
            chk("midcol done", done, 0);
            chk("midcol readies", {ptr_ready, col_ready}, 0);
            chk("midcol err_code", err_code, 0);
            sb.delete();
            @(negedge clk);
            rst = 1'b1;
            $display("mid-COL reset: busy=%0d done=%0d", busy, done);
            run_vec(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
